// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared bus lane_select.
// Define BUS_ARB_TIMEOUT_EN to bound lock tenure to MAX_HOLD cycles.
module bus_arbiter #(
  parameter int LANES    = 6,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         req,
  input  logic [LANES-1:0]         lock,
  output logic [LANES-1:0]         lane_select,
  output logic                     grant_valid,
  output logic [$clog2(LANES)-1:0] grant_id,
  output logic                     timeout
);

  localparam int IW = $clog2(LANES);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] sel_q, sel_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    pick;
  logic             to_q, to_d;
  logic             any_req;
  logic             force_rr;
  logic             grant_new;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
  assign force_rr = (hold_q == HW'(MAX_HOLD - 1));
`else
  assign force_rr = 1'b0;
`endif

  assign any_req = |req;

  // First requester after last_q, wrapping; descending loop so the
  // nearest candidate is the final assignment.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    idx  = 0;
    cand = '0;
    pick = last_q;
    for (int k = LANES; k >= 1; k--) begin
      idx  = (int'(last_q) + k) % LANES;
      cand = IW'(idx);
      if (req[cand]) pick = cand;
    end
  end

  // State register: grant, pointer and tenure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      id_q    <= '0;
      last_q  <= IW'(LANES - 1);
      to_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      last_q  <= last_d;
      to_q    <= to_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // Next-state: release, keep under lock, or rearbitrate.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    id_d      = id_q;
    last_d    = last_q;
    to_d      = 1'b0;
    grant_new = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) grant_new = 1'b1;
        else sel_d = '0;
      end
      GRANT: begin
        if (!req[id_q]) begin
          if (any_req) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end else if (lock[id_q] && !force_rr) begin
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d = hold_q + 1'b1;
`endif
        end else begin
          grant_new = 1'b1;
          to_d = force_rr && lock[id_q] &&
                 (pick != id_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      state_d = GRANT;
      sel_d   = {{(LANES-1){1'b0}}, 1'b1} << pick;
      id_d    = pick;
      last_d  = pick;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    lane_select = sel_q;
    grant_valid = (state_q == GRANT);
    grant_id    = id_q;
    timeout     = to_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter.
// Scoreboard of expected grants compared one cycle after drive.
module tb_bus_arbiter;

  localparam int LANES    = 6;
  localparam int MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] req = '0;
  logic [5:0] lock = '0;
  logic [5:0] lane_select;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout;

  always #5 clk = ~clk;

  bus_arbiter #(
    .LANES(LANES),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .lock(lock),
    .lane_select(lane_select),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout(timeout)
  );

  typedef struct packed {
    logic [5:0] sel;
    logic       valid;
    logic [2:0] id;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_valid;
  int   m_id, m_last, m_hold;
  bit   m_to;
  int   wait_cnt[LANES];
  int   max_wait = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 1'b0;
    m_id    = 0;
    m_last  = LANES - 1;
    m_hold  = 0;
    m_to    = 1'b0;
    sb.delete();
  endtask

  task automatic m_grant(input int p);
    m_valid = 1'b1;
    m_id    = p;
    m_last  = p;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [5:0] r,
                            input logic [5:0] l);
    int   p;
    int   c;
    exp_t e;
    p = -1;
    for (int k = 1; k <= LANES; k++) begin
      c = (m_last + k) % LANES;
      if (p < 0 && r[c]) p = c;
    end
    m_to = 1'b0;
    if (!m_valid || !r[m_id]) begin
      if (p >= 0) m_grant(p);
      else begin
        m_valid = 1'b0;
        m_hold  = 0;
      end
    end else if (l[m_id] &&
                 !(TO_EN && m_hold == MAX_HOLD - 1)) begin
      m_hold++;
    end else begin
      m_to = TO_EN && l[m_id] && (p != m_id);
      m_grant(p);
    end
    e.sel   = m_valid ? (6'b1 << m_id) : 6'b0;
    e.valid = m_valid;
    e.id    = 3'(m_id);
    e.to    = m_to;
    sb.push_back(e);
  endtask

  task automatic tick(input logic [5:0] r,
                      input logic [5:0] l);
    exp_t e;
    req  = r;
    lock = l;
    model_step(r, l);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sel", 32'(lane_select), 32'(e.sel));
    chk("valid", 32'(grant_valid), 32'(e.valid));
    chk("id", 32'(grant_id), 32'(e.id));
    chk("timeout", 32'(timeout), 32'(e.to));
    chk("onehot0", 32'($onehot0(lane_select)), 32'd1);
    chk("gnt_req", 32'(!grant_valid || r[grant_id]), 32'd1);
  endtask

  initial begin
    logic [5:0] rr_exp [5];
    logic [5:0] rv;
    logic [5:0] lv;
    logic [5:0] e4;
    rr_exp = '{6'b000001, 6'b000100, 6'b100000,
               6'b000001, 6'b000100};

    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(lane_select), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick(6'b000000, 6'b000000);
      chk("idle_sel", 32'(lane_select), 32'd0);
      chk("idle_id", 32'(grant_id), 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      tick(6'b100101, 6'b000000);
      chk("rr_seq", 32'(lane_select), 32'(rr_exp[i]));
    end

    for (int i = 0; i < 3; i++) begin
      tick(6'b001000, 6'b001000);
      chk("lock3", 32'(lane_select), 32'h08);
    end
    tick(6'b000010, 6'b000000);
    chk("handoff", 32'(lane_select), 32'h02);

    for (int i = 0; i < 10; i++) begin
      tick(6'b010100, 6'b000100);
      e4 = 6'b000100;
      if (TO_EN && i == 4) e4 = 6'b010000;
      if (!TO_EN || i <= 4) begin
        chk("lock2", 32'(lane_select), 32'(e4));
        chk("lock2_to", 32'(timeout),
            32'(TO_EN && i == 4));
      end
    end

    tick(6'b100000, 6'b000000);
    chk("lane5", 32'(lane_select), 32'h20);
    tick(6'b100000, 6'b000000);
    chk("lane5_hold", 32'(lane_select), 32'h20);
    rst_n = 1'b0;
    #1;
    chk("async_sel", 32'(lane_select), 32'd0);
    chk("async_valid", 32'(grant_valid), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(6'b100001, 6'b000000);
    chk("post_rst", 32'(lane_select), 32'h01);
    tick(6'b100001, 6'b000000);
    chk("post_rst2", 32'(lane_select), 32'h20);
    tick(6'b000000, 6'b000000);
    chk("drop", 32'(lane_select), 32'd0);

    rv = '0;
    for (int i = 0; i < 5000; i++) begin
      rv = rv ^ (6'($urandom) & 6'($urandom));
      lv = 6'($urandom) & 6'($urandom);
      tick(rv, lv);
    end

    for (int j = 0; j < LANES; j++) wait_cnt[j] = 0;
    for (int i = 0; i < 5000; i++) begin
      rv = rv ^ (6'($urandom) & 6'($urandom) &
                 6'($urandom));
      tick(rv, 6'b000000);
      for (int j = 0; j < LANES; j++) begin
        if (!rv[j] || lane_select[j]) wait_cnt[j] = 0;
        else if (grant_valid) wait_cnt[j]++;
        if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
      end
    end
    chk("fair", 32'(max_wait <= LANES - 1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that owns the one-hot `lane_select` input of the shared `bus` mux.
- Up to LANES modules (A/B/IR/PC/RAM/ALU drivers) request the bus; exactly one is granted per cycle, or none.
- Adds lock (multi-cycle tenure) so a driver can hold the bus across consecutive transfers.
- Sits between the control sequencer's request strobes and the bus instance.

Parameters:
- LANES, 6, number of requesters/bus lanes; must be >= 2.
- MAX_HOLD, 4, max consecutive locked cycles for one holder; used only when BUS_ARB_TIMEOUT_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  LANES  per-lane bus request, level-sensitive.
- lock  input  LANES  per-lane hold request; meaningful only for the current holder.
- lane_select  output  LANES  registered one-hot grant (or all zero); drives bus `lane_select`.
- grant_valid  output  1  registered; 1 when lane_select is non-zero.
- grant_id  output  $clog2(LANES)  registered binary index of the granted lane; holds its last value when grant_valid=0.
- timeout  output  1  one-cycle pulse when a lock is broken by MAX_HOLD; tied 0 when the feature is off.

Behaviour:
- Reset (async assert, sync release):
  - lane_select=0, grant_valid=0, grant_id=0, timeout=0.
  - Round-robin pointer last=LANES-1, so lane 0 has highest priority first.
  - hold_cnt=0, state IDLE.
- All outputs are registered. A request sampled at edge N produces its grant after edge N, visible for cycle N+1 (latency 1).
- Priority search order: last+1, last+2, ... wrapping modulo LANES. On every new grant, last := granted index.
- State IDLE (no grant):
  - If any req, go to GRANT on the first requester in search order.
  - Otherwise stay IDLE with lane_select=0.
- State GRANT (holder h):
  - req[h]=0 → release. If another req exists, grant it at the same edge (no idle gap); otherwise go IDLE.
  - req[h]=1, lock[h]=1 → keep h; hold_cnt++ (saturating).
  - req[h]=1, lock[h]=0 → rearbitrate from h+1. h is re-granted only if no other lane requests.
  - lock on non-holder lanes is ignored.
- hold_cnt clears to 0 on every new grant or on release.
- lane_select is always one-hot or zero. grant_valid == |lane_select. grant_id == index of the set bit whenever grant_valid=1.
- Simultaneous requests: pure round-robin order from last+1. No fixed-priority lane.
- A request dropped in the same cycle it would be granted is not granted (the sampled value decides).
- rst_n asserted mid-tenure clears the grant immediately (async). The bus sees no driver until a request is re-sampled after release.
- Assertions (bench): $onehot0(lane_select); grant_valid implies req[grant_id] was high at the preceding edge.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - When the holder has held for MAX_HOLD consecutive locked cycles (hold_cnt==MAX_HOLD-1 with lock still high), the next edge forces rearbitration from h+1 as if lock were 0.
  - timeout pulses 1 for that one cycle only if another lane took the grant.
  - If no other lane requests, h keeps the bus, hold_cnt restarts at 0, and there is no timeout pulse.
- Undefined: lock holds the bus indefinitely, hold_cnt is not implemented, timeout=0.

Test Plan:
- Reset then req=6'b000000 for 5 cycles → lane_select=0, grant_valid=0, grant_id=0.
- From reset, req=6'b100101 held, lock=0 → grants lane 0, 2, 5, 0, 2 on successive cycles. Each grant appears one cycle after sampling.
- Lane 3 alone req+lock for 3 cycles, then req=0 while lane 1 requests in the same cycle → lane_select=6'b001000 for 3 cycles, then 6'b000010 on the next cycle with no zero gap.
- Lane 2 holds with lock=1 for 10 cycles while lane 4 requests:
  - macro off → lane 2 is held all 10 cycles, lane 4 is never granted.
  - macro on with MAX_HOLD=4 → lane 2 for 4 cycles, then lane 4 granted with timeout=1 for one cycle.
- rst_n pulsed low mid-grant of lane 5 → lane_select drops to 0 asynchronously. After release with req=6'b100001, lane 0 is granted first (pointer reset).
- Randomised req/lock for 10k cycles → onehot0 and grant-implies-request assertions never fire, and every persistently requesting lane is granted within LANES grants (lock=0).
